// File: rtl/issue_pair_buffer.sv
// issue_pair_buffer
//   Instruction buffer between Fetch and Decode for a dual-issue pipeline.
//   Fetch pushes aligned pairs into a circular store. The two oldest entries
//   are offered as the candidate pair. One or both of them issue into the
//   Decode registers, depending on Split and StallD.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   FetchValid, InstrF0/F1, PCF   fetched pair (F0 older, F1 at PCF+4)
//   FetchReady                    room for a pair (registered occupancy only)
//   CandValidA/B, CandInstrA/B    head / head+1 entries (combinational)
//   Split, StallD, FlushD         issue control from the hazard checker / Decode
//   ValidDA/DB, InstrDA/DB, PCDA/DB  registered Decode slots
module issue_pair_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             FetchValid,
    input  logic [WIDTH-1:0] InstrF0,
    input  logic [WIDTH-1:0] InstrF1,
    input  logic [WIDTH-1:0] PCF,
    output logic             FetchReady,
    output logic             CandValidA,
    output logic             CandValidB,
    output logic [WIDTH-1:0] CandInstrA,
    output logic [WIDTH-1:0] CandInstrB,
    input  logic             Split,
    input  logic             StallD,
    input  logic             FlushD,
    output logic             ValidDA,
    output logic             ValidDB,
    output logic [WIDTH-1:0] InstrDA,
    output logic [WIDTH-1:0] InstrDB,
    output logic [WIDTH-1:0] PCDA,
    output logic [WIDTH-1:0] PCDB
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] READY_LIM = (PW+1)'(DEPTH - 2);

    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] pc_q    [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_p1, wr_ptr_p1;
    logic [PW:0]   count_q, count_d;
    logic          push;
    logic [1:0]    npop;

    logic             valid_da_q, valid_da_d, valid_db_q, valid_db_d;
    logic [WIDTH-1:0] instr_da_q, instr_da_d, instr_db_q, instr_db_d;
    logic [WIDTH-1:0] pc_da_q, pc_da_d, pc_db_q, pc_db_d;

    assign rd_ptr_p1 = rd_ptr_q + PW'(1);
    assign wr_ptr_p1 = wr_ptr_q + PW'(1);

    // Ready looks only at the registered count, so it has no path from
    // Split/StallD and never relies on a same-cycle pop.
    assign FetchReady = (count_q <= READY_LIM);
    assign push       = FetchValid & FetchReady & ~FlushD;

    assign CandValidA = (count_q >= (PW+1)'(1));
    assign CandValidB = (count_q >= (PW+1)'(2));
    assign CandInstrA = instr_q[rd_ptr_q];
    assign CandInstrB = instr_q[rd_ptr_p1];

    always_comb begin
        npop = 2'd0;
        if (!StallD && !FlushD && count_q != '0) begin
            npop = (count_q == (PW+1)'(1) || Split) ? 2'd1 : 2'd2;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(2) : wr_ptr_q;
        // Flush empties the buffer by collapsing rd onto wr (push is off).
        rd_ptr_d = FlushD ? wr_ptr_q : rd_ptr_q + PW'(npop);
        count_d  = FlushD ? '0
                 : count_q + (push ? (PW+1)'(2) : '0) - (PW+1)'(npop);
    end

    always_comb begin
        valid_da_d = valid_da_q;
        valid_db_d = valid_db_q;
        instr_da_d = instr_da_q;
        instr_db_d = instr_db_q;
        pc_da_d    = pc_da_q;
        pc_db_d    = pc_db_q;
        if (FlushD) begin
            valid_da_d = 1'b0;
            valid_db_d = 1'b0;
        end else if (!StallD) begin
            valid_da_d = (npop != 2'd0);
            valid_db_d = (npop == 2'd2);
            instr_da_d = instr_q[rd_ptr_q];
            instr_db_d = instr_q[rd_ptr_p1];
            pc_da_d    = pc_q[rd_ptr_q];
            pc_db_d    = pc_q[rd_ptr_p1];
        end
    end

    // Entry payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q]  <= InstrF0;
            pc_q[wr_ptr_q]     <= PCF;
            instr_q[wr_ptr_p1] <= InstrF1;
            pc_q[wr_ptr_p1]    <= PCF + WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_da_q <= 1'b0;
            valid_db_q <= 1'b0;
            instr_da_q <= '0;
            instr_db_q <= '0;
            pc_da_q    <= '0;
            pc_db_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            valid_da_q <= valid_da_d;
            valid_db_q <= valid_db_d;
            instr_da_q <= instr_da_d;
            instr_db_q <= instr_db_d;
            pc_da_q    <= pc_da_d;
            pc_db_q    <= pc_db_d;
        end
    end

    assign ValidDA = valid_da_q;
    assign ValidDB = valid_db_q;
    assign InstrDA = instr_da_q;
    assign InstrDB = instr_db_q;
    assign PCDA    = pc_da_q;
    assign PCDB    = pc_db_q;
endmodule

// File: tb/tb_issue_pair_buffer.sv
// Bench for issue_pair_buffer: queue-based reference model plus directed
// scenarios with literal expectations and a randomized in-order stream check.
module tb_issue_pair_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        FetchValid = 1'b0;
    logic [31:0] InstrF0 = '0, InstrF1 = '0, PCF = '0;
    logic        FetchReady, CandValidA, CandValidB;
    logic [31:0] CandInstrA, CandInstrB;
    logic        Split = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        ValidDA, ValidDB;
    logic [31:0] InstrDA, InstrDB, PCDA, PCDB;

    int tests = 0;
    int fails = 0;

    issue_pair_buffer #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .FetchValid(FetchValid), .InstrF0(InstrF0), .InstrF1(InstrF1), .PCF(PCF),
        .FetchReady(FetchReady),
        .CandValidA(CandValidA), .CandValidB(CandValidB),
        .CandInstrA(CandInstrA), .CandInstrB(CandInstrB),
        .Split(Split), .StallD(StallD), .FlushD(FlushD),
        .ValidDA(ValidDA), .ValidDB(ValidDB),
        .InstrDA(InstrDA), .InstrDB(InstrDB), .PCDA(PCDA), .PCDB(PCDB)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'h20 + ((pc - 32'h400) >> 1);
    endfunction

    // ---------------- reference model ----------------
    ent_t q[$];
    logic m_va, m_vb;
    ent_t m_a, m_b;

    always @(posedge clk or negedge rst_n) begin : model
        int cnt;
        int np;
        bit rdy;
        if (!rst_n) begin
            q.delete();
            m_va = 1'b0; m_vb = 1'b0;
            m_a = '0; m_b = '0;
        end else begin
            cnt = q.size();
            rdy = (DEPTH - cnt) >= 2;
            if (FlushD) begin
                q.delete();
                m_va = 1'b0; m_vb = 1'b0;
            end else begin
                if (StallD || cnt == 0) np = 0;
                else if (cnt == 1 || Split) np = 1;
                else np = 2;
                if (!StallD) begin
                    m_va = (np >= 1);
                    m_vb = (np == 2);
                    if (np >= 1) m_a = q.pop_front();
                    if (np == 2) m_b = q.pop_front();
                end
                if (FetchValid && rdy) begin
                    q.push_back({InstrF0, PCF});
                    q.push_back({InstrF1, PCF + 32'd4});
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare DUT against the model; called once per cycle, #1 after the edge.
    task automatic compare();
        chk("m_FetchReady", 32'(FetchReady), 32'((DEPTH - q.size()) >= 2));
        chk("m_CandValidA", 32'(CandValidA), 32'(q.size() >= 1));
        chk("m_CandValidB", 32'(CandValidB), 32'(q.size() >= 2));
        if (q.size() >= 1) chk("m_CandInstrA", CandInstrA, q[0].instr);
        if (q.size() >= 2) chk("m_CandInstrB", CandInstrB, q[1].instr);
        chk("m_ValidDA", 32'(ValidDA), 32'(m_va));
        chk("m_ValidDB", 32'(ValidDB), 32'(m_vb));
        if (m_va) begin
            chk("m_InstrDA", InstrDA, m_a.instr);
            chk("m_PCDA", PCDA, m_a.pc);
        end
        if (m_vb) begin
            chk("m_InstrDB", InstrDB, m_b.instr);
            chk("m_PCDB", PCDB, m_b.pc);
        end
        tests++;
        if (q.size() > DEPTH) begin
            fails++;
            $display("FAIL count_range: model occupancy %0d above %0d", q.size(), DEPTH);
        end
    endtask

    task automatic drive(input bit fv, input logic [31:0] pc, input bit sp,
                         input bit st, input bit fl);
        FetchValid = fv;
        PCF        = pc;
        InstrF0    = ins_of(pc);
        InstrF1    = ins_of(pc + 32'd4);
        Split      = sp;
        StallD     = st;
        FlushD     = fl;
    endtask

    task automatic step(input bit fv, input logic [31:0] pc, input bit sp,
                        input bit st, input bit fl);
        drive(fv, pc, sp, st, fl);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Async reset asserted between edges; outputs must clear before any clk.
    task automatic do_reset();
        drive(0, 32'h0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_CandValidA", 32'(CandValidA), 32'd0);
        chk("rst_async_FetchReady", 32'(FetchReady), 32'd1);
        chk("rst_async_ValidDA", 32'(ValidDA), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [31:0] fpc, exp_pc;
        int pushed, issued, cyc;
        bit st, sp, fv, accept;

        // ---- reset state ----
        #3 rst_n = 1'b0;
        #4;
        chk("rst_FetchReady", 32'(FetchReady), 32'd1);
        chk("rst_CandValidA", 32'(CandValidA), 32'd0);
        chk("rst_CandValidB", 32'(CandValidB), 32'd0);
        chk("rst_ValidDA", 32'(ValidDA), 32'd0);
        chk("rst_ValidDB", 32'(ValidDB), 32'd0);
        chk("rst_InstrDA", InstrDA, 32'd0);
        chk("rst_PCDB", PCDB, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- single pair, dual issue ----
        step(1, 32'h400, 0, 0, 0);
        chk("t1_CandInstrA", CandInstrA, 32'h20);
        chk("t1_CandInstrB", CandInstrB, 32'h22);
        step(0, 32'h0, 0, 0, 0);
        chk("t1_ValidDA", 32'(ValidDA), 32'd1);
        chk("t1_ValidDB", 32'(ValidDB), 32'd1);
        chk("t1_PCDA", PCDA, 32'h400);
        chk("t1_PCDB", PCDB, 32'h404);
        chk("t1_empty", 32'(CandValidA), 32'd0);

        // ---- split every cycle ----
        do_reset();
        step(1, 32'h400, 1, 0, 0);
        step(1, 32'h408, 1, 0, 0);
        chk("t2_PCDA0", PCDA, 32'h400);
        chk("t2_ValidDB0", 32'(ValidDB), 32'd0);
        chk("t2_ready_cnt3", 32'(FetchReady), 32'd0);
        step(0, 32'h0, 1, 0, 0);
        chk("t2_PCDA1", PCDA, 32'h404);
        chk("t2_ready_back", 32'(FetchReady), 32'd1);
        step(0, 32'h0, 1, 0, 0);
        chk("t2_PCDA2", PCDA, 32'h408);
        step(0, 32'h0, 1, 0, 0);
        chk("t2_PCDA3", PCDA, 32'h40C);
        chk("t2_ValidDB3", 32'(ValidDB), 32'd0);

        // ---- split once, then re-pair across fetch pairs ----
        do_reset();
        step(1, 32'h400, 0, 0, 0);
        step(1, 32'h408, 1, 0, 0);
        chk("t3_PCDA0", PCDA, 32'h400);
        chk("t3_ValidDB0", 32'(ValidDB), 32'd0);
        step(0, 32'h0, 0, 0, 0);
        chk("t3_PCDA1", PCDA, 32'h404);
        chk("t3_PCDB1", PCDB, 32'h408);
        chk("t3_ValidDB1", 32'(ValidDB), 32'd1);

        // ---- stall with full buffer ----
        do_reset();
        step(1, 32'h400, 0, 0, 0);
        step(1, 32'h408, 0, 0, 0);
        step(1, 32'h410, 0, 1, 0);
        step(1, 32'h418, 0, 1, 0);
        step(1, 32'h418, 0, 1, 0);
        chk("t4_hold_PCDA", PCDA, 32'h400);
        chk("t4_hold_PCDB", PCDB, 32'h404);
        chk("t4_full_ready", 32'(FetchReady), 32'd0);
        chk("t4_full_candA", CandInstrA, ins_of(32'h408));
        step(1, 32'h418, 0, 0, 0);
        chk("t4_rel_PCDA", PCDA, 32'h408);
        chk("t4_rel_PCDB", PCDB, 32'h40C);
        step(1, 32'h418, 0, 0, 0);
        chk("t4_rel2_PCDA", PCDA, 32'h410);
        step(0, 32'h0, 0, 0, 0);
        chk("t4_rel3_PCDB", PCDB, 32'h41C);

        // ---- flush with fetch and stall ----
        do_reset();
        step(1, 32'h400, 0, 0, 0);
        step(1, 32'h408, 0, 1, 1);
        chk("t5_candA", 32'(CandValidA), 32'd0);
        chk("t5_ValidDA", 32'(ValidDA), 32'd0);
        chk("t5_ValidDB", 32'(ValidDB), 32'd0);
        step(1, 32'h500, 0, 0, 0);
        chk("t5_cand_500", CandInstrA, ins_of(32'h500));
        step(0, 32'h0, 0, 0, 0);
        chk("t5_PCDA", PCDA, 32'h500);
        chk("t5_PCDB", PCDB, 32'h504);

        // ---- random split/stall stream, 20 pairs, wrap-around ----
        do_reset();
        fpc = 32'h600; exp_pc = 32'h600;
        pushed = 0; issued = 0; cyc = 0;
        while ((pushed < 20 || issued < 40) && cyc < 600) begin
            fv = (pushed < 20) && ($urandom_range(0, 4) != 0);
            sp = $urandom_range(0, 1) == 1;
            st = $urandom_range(0, 3) == 0;
            accept = fv && ((DEPTH - q.size()) >= 2);
            step(fv, fpc, sp, st, 0);
            if (accept) begin
                fpc += 32'd8;
                pushed++;
            end
            if (!st) begin
                if (ValidDA) begin
                    chk("t6_order_A", PCDA, exp_pc);
                    exp_pc += 32'd4; issued++;
                end
                if (ValidDB) begin
                    chk("t6_order_B", PCDB, exp_pc);
                    exp_pc += 32'd4; issued++;
                end
            end
            cyc++;
        end
        chk("t6_issued", 32'(issued), 32'd40);
        chk("t6_pushed", 32'(pushed), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
